// File: rtl/lfsr_decode_if.sv
// ---------------------------------------------------------------------------
// lfsr_decode_if
//   Request/response bundle for the LFSR decoder.
//
//   master (requester) drives:
//     start    request pulse, sampled only while the decoder is idle
//     enable   search advances only while high
//     lfsr_in  LFSR state to decode, captured on the accepted start edge
//
//   slave (decoder) drives:
//     busy     search in progress
//     done     one-cycle result pulse
//     index    decoded index; holds until the next done
//     invalid  qualifies done: 1 = value is not reachable from SEED
// ---------------------------------------------------------------------------
interface lfsr_decode_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             enable;
  logic [WIDTH-1:0] lfsr_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] index;
  logic             invalid;

  modport master (
    output start, enable, lfsr_in,
    input  busy, done, index, invalid
  );

  modport slave (
    input  start, enable, lfsr_in,
    output busy, done, index, invalid
  );
endinterface

// File: rtl/lfsr_decode.sv
// ---------------------------------------------------------------------------
// lfsr_decode
//   Converts an LFSR state into its binary sequence index, i.e. the number of
//   up-steps needed to reach it from SEED. A walker LFSR steps from SEED once
//   per enabled cycle until it equals the captured target, or until every
//   reachable index has been tried.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    lfsr_decode_if.slave: start/enable/lfsr_in in,
//            busy/done/index/invalid out
//
//   With enable held high, a state at index k returns done k+1 cycles after
//   the start edge; the worst case is 2^WIDTH-1 cycles.
// ---------------------------------------------------------------------------
module lfsr_decode #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 'hB8,
  parameter logic [WIDTH-1:0] SEED  = 'h01
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_decode_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  // Last index a maximal LFSR can reach: 2^WIDTH-2. Stopping here keeps cnt
  // from ever wrapping.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] walker;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] target;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] index_q;
  logic             invalid_q;

  // Same up-step as the companion counter.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
    logic fb;
    fb = ^(cur & TAPS);
    return {cur[WIDTH-2:0], fb};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      walker    <= SEED;
      cnt       <= '0;
      target    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      index_q   <= '0;
      invalid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Accepted regardless of enable; a start coinciding with done also
          // lands here because the result edge already returned to IDLE.
          if (bus.start) begin
            target <= bus.lfsr_in;
            walker <= SEED;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (bus.enable) begin
            if (target == '0) begin
              // All-zero is the lock-up state; no walk ever reaches it.
              done_q    <= 1'b1;
              invalid_q <= 1'b1;
              index_q   <= ALL_ONES;
              busy_q    <= 1'b0;
              state     <= IDLE;
            end else if (walker == target) begin
              done_q    <= 1'b1;
              invalid_q <= 1'b0;
              index_q   <= cnt;
              busy_q    <= 1'b0;
              state     <= IDLE;
            end else if (cnt == CNT_LAST) begin
              // Exhausted the longest possible orbit: the value lies on a
              // different cycle (non-maximal TAPS or otherwise unreachable).
              done_q    <= 1'b1;
              invalid_q <= 1'b1;
              index_q   <= ALL_ONES;
              busy_q    <= 1'b0;
              state     <= IDLE;
            end else begin
              walker <= lfsr_next(walker);
              cnt    <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.index   = index_q;
  assign bus.invalid = invalid_q;

endmodule
